exec_halt_controller: RTL and testbench

//  Execution-control unit between decode and the execution driver. Generalises halt detection into
//  a run/halt/single-step FSM with PC breakpoint and cause reporting. Also holds per-register

---
 rtl/exec_halt_controller.sv | 211 +++++++++++++++++++++
 tb/tb_exec_halt_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/exec_halt_controller.sv
// ---------------------------------------------------------------------------
// exec_halt_controller
//   Execution-control unit that sits between decode and the execution driver.
//   The run-control FSM has the states IDLE, RUN, STEP, BREAK and HALT_OP.
//   It provides halt-opcode detection, a PC breakpoint that is masked after a
//   resume, single-step, cause reporting and an enabled-cycle counter. It also
//   holds the per-register load/ALU writeback mux selects.
//
// Ports
//   clk, rst_n            clock and synchronous active-low reset
//   opcode, opcode_valid  opcode of the instruction at pc, and its valid flag
//   pc                    current program counter
//   start/resume/step     level-sampled run-control requests
//   bkpt_en, bkpt_addr    PC breakpoint
//   load_valid/load_dest  memory-load writeback to a register
//   alu_valid/alu_dest    ALU writeback to a register
//   exec_enable           registered enable to the execution driver
//   halted                1 in IDLE, BREAK or HALT_OP
//   halt_cause            0 none, 1 halt opcode, 2 breakpoint, 3 step done
//   load_mux_sel          per-register select (1 = load data, 0 = ALU data)
//   run_cycles            wrapping count of cycles with exec_enable = 1
// ---------------------------------------------------------------------------

// One writeback select bit. A load to this register wins over an ALU write to
// the same register. Destinations that match no register index are ignored.
module ehc_sel_bit #(
  parameter int SEL_WIDTH = 3,
  parameter int IDX       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [SEL_WIDTH-1:0] load_dest,
  input  logic                 alu_valid,
  input  logic [SEL_WIDTH-1:0] alu_dest,
  output logic                 sel
);
  logic sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if (load_valid && (load_dest == SEL_WIDTH'(IDX)))   sel_d = 1'b1;
    else if (alu_valid && (alu_dest == SEL_WIDTH'(IDX))) sel_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sel_q <= 1'b0;
    else        sel_q <= sel_d;
  end

  assign sel = sel_q;
endmodule

module exec_halt_controller #(
  parameter int                     OPCODE_SIZE = 8,
  parameter logic [OPCODE_SIZE-1:0] HALT_OPCODE = 8'h01,
  parameter int                     PC_WIDTH    = 16,
  parameter int                     NUM_REGS    = 8,
  parameter int                     SEL_WIDTH   = $clog2(NUM_REGS),
  parameter int                     CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   opcode_valid,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   start,
  input  logic                   resume,
  input  logic                   step,
  input  logic                   bkpt_en,
  input  logic [PC_WIDTH-1:0]    bkpt_addr,
  input  logic                   load_valid,
  input  logic [SEL_WIDTH-1:0]   load_dest,
  input  logic                   alu_valid,
  input  logic [SEL_WIDTH-1:0]   alu_dest,
  output logic                   exec_enable,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [NUM_REGS-1:0]    load_mux_sel,
  output logic [CNT_WIDTH-1:0]   run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_STEP    = 3'd2,
    S_BREAK   = 3'd3,
    S_HALT_OP = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_HALT = 2'd1;
  localparam logic [1:0] CAUSE_BKPT = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  state_e               state_q, state_d;
  logic [1:0]           cause_q, cause_d;
  logic                 en_q, en_d;
  // The breakpoint mask is armed on resume and holds the PC seen at resume.
  // It stays armed until the PC moves away from that value, so resuming at
  // the breakpoint address does not break again immediately.
  logic                 mask_q, mask_d;
  logic [PC_WIDTH-1:0]  mask_pc_q, mask_pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic halt_hit, bkpt_hit;

  assign halt_hit = opcode_valid && (opcode == HALT_OPCODE);
  assign bkpt_hit = opcode_valid && bkpt_en && (pc == bkpt_addr) &&
                    !(mask_q && (pc == mask_pc_q));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cause_q   <= CAUSE_NONE;
      en_q      <= 1'b0;
      mask_q    <= 1'b0;
      mask_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      en_q      <= en_d;
      mask_q    <= mask_d;
      mask_pc_q <= mask_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    mask_d    = mask_q;
    mask_pc_d = mask_pc_q;
    unique case (state_q)
      S_IDLE, S_HALT_OP: begin
        if (start) begin
          state_d = S_RUN;
          cause_d = CAUSE_NONE;
          mask_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (mask_q && (pc != mask_pc_q)) mask_d = 1'b0;
        // A halt opcode takes priority over a breakpoint at the same PC.
        if (halt_hit) begin
          state_d = S_HALT_OP;
          cause_d = CAUSE_HALT;
        end else if (bkpt_hit) begin
          state_d = S_BREAK;
          cause_d = CAUSE_BKPT;
        end
      end
      S_BREAK: begin
        if (step) begin
          state_d = S_STEP;
        end else if (resume) begin
          state_d   = S_RUN;
          cause_d   = CAUSE_NONE;
          mask_d    = 1'b1;
          mask_pc_d = pc;
        end
      end
      S_STEP: begin
        // STEP always lasts exactly one cycle.
        if (halt_hit) begin
          state_d = S_HALT_OP;
          cause_d = CAUSE_HALT;
        end else begin
          state_d = S_BREAK;
          cause_d = CAUSE_STEP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cause_d = CAUSE_NONE;
        mask_d  = 1'b0;
      end
    endcase
    // The enable is registered from the next state. It therefore drops in
    // the cycle after a halt opcode or breakpoint is detected.
    en_d  = (state_d == S_RUN) || (state_d == S_STEP);
    cnt_d = en_q ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  // Output logic
  always_comb begin
    exec_enable = en_q;
    halted      = (state_q == S_IDLE) || (state_q == S_BREAK) ||
                  (state_q == S_HALT_OP);
    halt_cause  = cause_q;
    run_cycles  = cnt_q;
  end

  // Writeback selects update in every FSM state, so writes that are already
  // in flight still complete while execution is halted.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sel
    ehc_sel_bit #(.SEL_WIDTH(SEL_WIDTH), .IDX(r)) u_sel (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_dest  (load_dest),
      .alu_valid  (alu_valid),
      .alu_dest   (alu_dest),
      .sel        (load_mux_sel[r])
    );
  end

endmodule

// File: tb/tb_exec_halt_controller.sv
module tb_exec_halt_controller;
  localparam int OW = 8, PW = 16, NR = 8, SW = 3, CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [OW-1:0] opcode;
  logic          opcode_valid;
  logic [PW-1:0] pc;
  logic          start, resume, step, bkpt_en;
  logic [PW-1:0] bkpt_addr;
  logic          load_valid, alu_valid;
  logic [SW-1:0] load_dest, alu_dest;
  logic          exec_enable, halted;
  logic [1:0]    halt_cause;
  logic [NR-1:0] load_mux_sel;
  logic [CW-1:0] run_cycles;

  int errors = 0;
  int checks = 0;

  exec_halt_controller #(
    .OPCODE_SIZE(OW), .HALT_OPCODE(8'h01), .PC_WIDTH(PW),
    .NUM_REGS(NR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .opcode_valid(opcode_valid),
    .pc(pc), .start(start), .resume(resume), .step(step),
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
    .load_valid(load_valid), .load_dest(load_dest),
    .alu_valid(alu_valid), .alu_dest(alu_dest),
    .exec_enable(exec_enable), .halted(halted), .halt_cause(halt_cause),
    .load_mux_sel(load_mux_sel), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle off the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full control state in one call: enable, halted, cause and count.
  task automatic chk_ctl(input string tag, input int en, input int hl,
                         input int cause, input int cnt);
    chk({tag, ".en"},    int'(exec_enable), en);
    chk({tag, ".halt"},  int'(halted),      hl);
    chk({tag, ".cause"}, int'(halt_cause),  cause);
    chk({tag, ".cnt"},   int'(run_cycles),  cnt);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; opcode_valid = 1'b0; pc = '0;
    start = 1'b1; resume = 1'b0; step = 1'b0;
    bkpt_en = 1'b0; bkpt_addr = '0;
    load_valid = 1'b0; load_dest = '0; alu_valid = 1'b0; alu_dest = '0;

    // 1: reset with start held high, then run and count.
    repeat (3) tick();
    chk_ctl("reset", 0, 1, 0, 0);
    chk("reset.sel", int'(load_mux_sel), 0);
    rst_n = 1'b1;
    tick();
    chk_ctl("run0", 1, 0, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("run.cnt", int'(run_cycles), i);
    end

    // 2: halt opcode, then step/resume ignored, then start restarts execution.
    opcode = 8'h01; opcode_valid = 1'b1;
    tick();
    chk_ctl("haltop", 0, 1, 1, 4);
    opcode_valid = 1'b0; step = 1'b1; resume = 1'b1;
    tick();
    chk_ctl("haltop.ign", 0, 1, 1, 4);
    step = 1'b0; resume = 1'b0; start = 1'b1;
    tick();
    chk_ctl("restart", 1, 0, 0, 4);
    start = 1'b0;

    // 3: breakpoint, single step, and masked resume.
    opcode = 8'h10; bkpt_en = 1'b1; bkpt_addr = 16'h0040;
    pc = 16'h003F; opcode_valid = 1'b1;
    tick();
    chk_ctl("pre_bkpt", 1, 0, 0, 5);
    pc = 16'h0040;
    tick();
    chk_ctl("bkpt", 0, 1, 2, 6);
    opcode_valid = 1'b0;
    tick();
    chk_ctl("bkpt.hold", 0, 1, 2, 6);
    step = 1'b1;
    tick();
    chk_ctl("step", 1, 0, 2, 6);
    step = 1'b0;
    tick();
    chk_ctl("step_done", 0, 1, 3, 7);
    resume = 1'b1; opcode_valid = 1'b1;
    tick();
    chk_ctl("resume", 1, 0, 0, 7);
    resume = 1'b0;
    tick();
    chk_ctl("masked", 1, 0, 0, 8);
    pc = 16'h0041;
    tick();
    chk_ctl("pc_moved", 1, 0, 0, 9);
    pc = 16'h0040;
    tick();
    chk_ctl("rebreak", 0, 1, 2, 10);

    // 6: step wins over resume; a halt opcode seen in STEP ends in HALT_OP.
    step = 1'b1; resume = 1'b1; opcode_valid = 1'b0;
    tick();
    chk_ctl("step_wins", 1, 0, 2, 10);
    step = 1'b0; resume = 1'b0; opcode = 8'h01; opcode_valid = 1'b1;
    tick();
    chk_ctl("step_halt", 0, 1, 1, 11);
    opcode_valid = 1'b0; opcode = 8'h10;

    // 4: writeback selects (updated while halted).
    load_valid = 1'b1; load_dest = 3'd3; alu_valid = 1'b1; alu_dest = 3'd3;
    tick();
    chk("sel.same", int'(load_mux_sel), 8'h08);
    load_valid = 1'b0;
    tick();
    chk("sel.alu", int'(load_mux_sel), 8'h00);
    load_valid = 1'b1; load_dest = 3'd2; alu_dest = 3'd5;
    tick();
    chk("sel.split", int'(load_mux_sel), 8'h04);
    load_dest = 3'd6; alu_dest = 3'd2;
    tick();
    chk("sel.swap", int'(load_mux_sel), 8'h40);
    load_valid = 1'b0; alu_valid = 1'b0;

    // 5: counter wraps 15 -> 0, then reset in the middle of a STEP.
    start = 1'b1;
    tick();
    chk_ctl("wrap.start", 1, 0, 0, 11);
    start = 1'b0;
    repeat (4) tick();
    chk("wrap.15", int'(run_cycles), 15);
    tick();
    chk("wrap.0", int'(run_cycles), 0);
    pc = 16'h0040; opcode_valid = 1'b1;
    tick();
    chk_ctl("bkpt2", 0, 1, 2, 1);
    opcode_valid = 1'b0; step = 1'b1;
    tick();
    chk_ctl("step2", 1, 0, 2, 1);
    rst_n = 1'b0; step = 1'b0;
    tick();
    chk_ctl("rst_step", 0, 1, 0, 0);
    chk("rst_step.sel", int'(load_mux_sel), 0);
    rst_n = 1'b1;
    tick();
    chk_ctl("idle", 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
